mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_pick.sv | 24 ++
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter.
// State encoding and requester ids used by mem_arbiter and mem_arb_pick.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } id_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between core (m0) and debug (m1).
// A tie goes to the requester that was not granted last.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  id_t  last,
    output id_t  winner,
    output logic valid
);

    // Sole requester wins outright; on a tie, the one not granted last wins.
    always_comb begin
        valid  = req0 | req1;
        winner = M0;
        if (req0 && req1) begin
            winner = (last == M1) ? M0 : M1;
        end else if (req1) begin
            winner = M1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single unified memory port.
// Define MEM_ARB_RR_EN for round-robin ties; default is fixed m0 priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_m0_req,
    input  logic              i_m0_we,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    input  logic              i_m1_req,
    input  logic              i_m1_we,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m0_done,
    output logic              o_m1_done,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    state_t            state;
    state_t            state_next;
    id_t               id_q;
    id_t               last;
    id_t               pick_id;
    logic              pick_valid;
    logic              grant;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    mem_arb_pick u_pick (
        .req0   (i_m0_req),
        .req1   (i_m1_req),
        .last   (last),
        .winner (pick_id),
        .valid  (pick_valid)
    );

    assign grant = (state == IDLE) && pick_valid;

    // State register; reset drops any access in flight without a done.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: grant from IDLE, wait for ack, one response cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (pick_valid) state_next = BUSY;
            BUSY:    if (i_mem_ack) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture the winner's access fields; held constant until next grant.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            id_q    <= M0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant) begin
            id_q    <= pick_id;
            we_q    <= (pick_id == M1) ? i_m1_we    : i_m0_we;
            addr_q  <= (pick_id == M1) ? i_m1_addr  : i_m0_addr;
            wdata_q <= (pick_id == M1) ? i_m1_wdata : i_m0_wdata;
        end
    end

    // Read data is taken only on the ack of a read; writes leave it alone.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rdata_q <= '0;
        end else if (state == BUSY && i_mem_ack && !we_q) begin
            rdata_q <= i_mem_rdata;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Remember who won last so the next tie goes the other way.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            last <= M1;
        end else if (grant) begin
            last <= pick_id;
        end
    end
`else
    // Pretending m1 always won last makes every tie go to m0.
    assign last = M1;
`endif

    assign o_mem_req   = (state == BUSY);
    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_rdata     = rdata_q;
    assign o_m0_done   = (state == RESP) && (id_q == M0);
    assign o_m1_done   = (state == RESP) && (id_q == M1);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter.
// Stimulus pushes expected accesses; a negedge monitor pops and checks.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic          id;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m1_req, m0_we, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_done, m1_done;
    logic [DW-1:0] rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done0 = 0;
    int done1 = 0;
    int done_cyc = 0;
    int busy_len = 0;
    int last_busy = 0;
    logic prev_req = 1'b0;
    bit auto_ack = 1'b1;
    int ack_delay = 0;
    int wait_cnt = 0;
    logic [DW-1:0] rd_base = '0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_m0_req    (m0_req),
        .i_m0_we     (m0_we),
        .i_m0_addr   (m0_addr),
        .i_m0_wdata  (m0_wdata),
        .i_m1_req    (m1_req),
        .i_m1_we     (m1_we),
        .i_m1_addr   (m1_addr),
        .i_m1_wdata  (m1_wdata),
        .o_m0_done   (m0_done),
        .o_m1_done   (m1_done),
        .o_rdata     (rdata),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_ack   (mem_ack),
        .i_mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/unexpected expected event", name);
    endtask

    function automatic exp_t mk(logic id, logic we, logic [AW-1:0] a,
                                logic [DW-1:0] wd, logic [DW-1:0] rd);
        exp_t e;
        e.id = id;
        e.we = we;
        e.addr = a;
        e.wdata = wd;
        e.rdata = rd;
        return e;
    endfunction

    // Memory model: acks after ack_delay wait cycles, rdata = base ^ addr.
    initial begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (auto_ack) begin
                if (mem_req) begin
                    if (wait_cnt == ack_delay) begin
                        mem_ack = 1'b1;
                        mem_rdata = rd_base ^ mem_addr;
                        wait_cnt = 0;
                    end else begin
                        mem_ack = 1'b0;
                        wait_cnt++;
                    end
                end else begin
                    mem_ack = 1'b0;
                    wait_cnt = 0;
                end
            end
        end
    end

    // Monitor: busy fields against scoreboard head, done pops it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
                busy_len = 0;
            end else begin
                if (mem_req) begin
                    if (sb.size() == 0) begin
                        fail_now("mem_req_unexpected");
                    end else begin
                        check("busy_we", 64'(mem_we), 64'(sb[0].we));
                        check("busy_addr", 64'(mem_addr), 64'(sb[0].addr));
                        check("busy_wdata", 64'(mem_wdata), 64'(sb[0].wdata));
                    end
                    busy_len++;
                end else if (prev_req) begin
                    last_busy = busy_len;
                    busy_len = 0;
                end
                prev_req = mem_req;
                if (m0_done || m1_done) begin
                    check("done_exclusive", 64'(m0_done & m1_done), 64'd0);
                    done_cyc = cyc;
                    if (m0_done) done0++;
                    else done1++;
                    if (sb.size() == 0) begin
                        fail_now("done_unexpected");
                    end else begin
                        e = sb.pop_front();
                        check("done_id", 64'(m1_done), 64'(e.id));
                        check("done_rdata", 64'(rdata), 64'(e.rdata));
                    end
                end
            end
        end
    end

    task automatic wait_dones(int target, int budget, string name);
        int n = 0;
        while ((done0 + done1) < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if ((done0 + done1) < target) fail_now(name);
    endtask

    task automatic run_one(logic m, logic we, logic [AW-1:0] a,
                           logic [DW-1:0] wd, int dly, logic [DW-1:0] base,
                           logic [DW-1:0] exp_rd, int exp_lat, string name);
        int c0;
        int tgt;
        sb.push_back(mk(m, we, a, wd, exp_rd));
        ack_delay = dly;
        rd_base = base;
        @(posedge clk);
        #1;
        if (m) begin
            m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = wd;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = wd;
        end
        c0 = cyc;
        tgt = done0 + done1 + 1;
        wait_dones(tgt, 40, {name, "_timeout"});
        check({name, "_latency"}, 64'(done_cyc - c0), 64'(exp_lat));
        @(posedge clk);
        #1;
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    initial begin
        int d0;
        int d1;
        int tot;
        rst = 1'b1;
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_m0_done", 64'(m0_done), 64'd0);
        check("rst_m1_done", 64'(m1_done), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_we_wdata", 64'({mem_we, mem_wdata}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_one(1'b0, 1'b0, 32'h10, 32'h0, 1, 32'hDEADBEFF,
                32'hDEADBEEF, 3, "m0_read");
        check("m0_read_rdata", 64'(rdata), 64'hDEADBEEF);
        check("m0_read_no_m1", 64'(done1), 64'd0);

        run_one(1'b1, 1'b1, 32'h20, 32'h55, 4, 32'h0,
                32'hDEADBEEF, 6, "m1_write");
        check("m1_write_busy_len", 64'(last_busy), 64'd5);
        check("m1_write_once", 64'(done1), 64'd1);
        check("m1_write_rdata", 64'(rdata), 64'hDEADBEEF);

        d0 = done0;
        d1 = done1;
        rd_base = 32'h1234_0000;
        ack_delay = 0;
`ifdef MEM_ARB_RR_EN
        sb.push_back(mk(1'b0, 1'b0, 32'h100, 32'h0, 32'h1234_0100));
        sb.push_back(mk(1'b1, 1'b0, 32'h200, 32'h0, 32'h1234_0200));
        sb.push_back(mk(1'b0, 1'b0, 32'h100, 32'h0, 32'h1234_0100));
        sb.push_back(mk(1'b1, 1'b0, 32'h200, 32'h0, 32'h1234_0200));
`else
        for (int i = 0; i < 4; i++)
            sb.push_back(mk(1'b0, 1'b0, 32'h100, 32'h0, 32'h1234_0100));
`endif
        @(posedge clk);
        #1;
        m0_req = 1; m0_we = 0; m0_addr = 32'h100; m0_wdata = '0;
        m1_req = 1; m1_we = 0; m1_addr = 32'h200; m1_wdata = '0;
        wait_dones(d0 + d1 + 4, 60, "both_timeout");
        @(posedge clk);
        #1;
        m0_req = 0;
        m1_req = 0;
`ifdef MEM_ARB_RR_EN
        check("both_m0_count", 64'(done0 - d0), 64'd2);
`else
        check("both_m0_count", 64'(done0 - d0), 64'd4);
`endif
        check("both_sb_empty", 64'(sb.size()), 64'd0);

        tot = done0 + done1;
        sb.push_back(mk(1'b0, 1'b0, 32'h30, 32'h0, 32'h0));
        ack_delay = 10;
        rd_base = '0;
        @(posedge clk);
        #1;
        m0_req = 1; m0_we = 0; m0_addr = 32'h30; m0_wdata = '0;
        @(posedge clk);
        #1;
        check("rst_busy_before", 64'(mem_req), 64'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_mid_mem_req", 64'(mem_req), 64'd0);
        check("rst_mid_done", 64'({m0_done, m1_done}), 64'd0);
        check("rst_mid_rdata", 64'(rdata), 64'd0);
        check("rst_mid_addr", 64'(mem_addr), 64'd0);
        m0_req = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_no_done", 64'(done0 + done1), 64'(tot));
        run_one(1'b0, 1'b0, 32'h10, 32'h0, 1, 32'hDEADBEFF,
                32'hDEADBEEF, 3, "post_rst_read");
        check("post_rst_rdata", 64'(rdata), 64'hDEADBEEF);

        auto_ack = 1'b0;
        tot = done0 + done1;
        @(posedge clk);
        #1;
        mem_ack = 1'b1;
        mem_rdata = 32'hBAD0_0001;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_mem_req", 64'(mem_req), 64'd0);
        check("idle_ack_rdata", 64'(rdata), 64'hDEADBEEF);
        sb.push_back(mk(1'b0, 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D));
        @(posedge clk);
        #1;
        m0_req = 1; m0_we = 0; m0_addr = 32'h40; m0_wdata = '0;
        @(posedge clk);
        #1;
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        mem_rdata = 32'hBAD0_0002;
        @(negedge clk);
        #1;
        check("resp_done", 64'(m0_done), 64'd1);
        @(posedge clk);
        #1;
        m0_req = 1'b0;
        @(negedge clk);
        check("resp_ack_mem_req", 64'(mem_req), 64'd0);
        check("resp_ack_no_done", 64'({m0_done, m1_done}), 64'd0);
        check("resp_ack_rdata", 64'(rdata), 64'hCAFE_F00D);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_mem_req", 64'(mem_req), 64'd0);
        check("stray_ack_done_count", 64'(done0 + done1), 64'(tot + 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
